// File: rtl/regf_mem_master_pkg.sv
// Shared types and constants for the regf mem-bus initiator.
// The response entry carries {rdata, err, wena, tag}; widths follow the master's defaults.
package regf_mem_master_pkg;

  localparam int RSP_DATA_W = 32;
  localparam int RSP_TAG_W  = 4;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] rdata;
    logic                  err;
    logic                  wena;
    logic [RSP_TAG_W-1:0]  tag;
  } rsp_entry_t;

endpackage

// File: rtl/regf_mem_master_fifo.sv
// Circular-buffer FIFO with occupancy counter; head is visible combinationally, 1-cycle push-to-pop.
// Pop on empty is ignored; the caller guarantees a push never meets a full buffer.
module regf_mem_master_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (occ == '0);
  assign full     = (occ == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !do_pop) begin
        occ <= occ + 1'b1;
      end else if (!push && do_pop) begin
        occ <= occ - 1'b1;
      end
    end
  end

endmodule

// File: rtl/regf_mem_master.sv
// Issues each accepted command as a single-cycle mem access and returns {rdata, err, wena, tag} in order, 2+ cycles later.
// Commands are credit-limited by FIFO occupancy plus the access in flight, so a stalled response stream never loses data.
module regf_mem_master
  import regf_mem_master_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = RSP_DATA_W,
  parameter int TAG_W     = RSP_TAG_W,
  parameter int RSP_DEPTH = 3
) (
  input  logic                 main_clk_i,
  input  logic                 main_rst_i,
  input  logic                 soft_rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [ADDR_W-1:0]    cmd_addr_i,
  input  logic                 cmd_wena_i,
  input  logic [DATA_W-1:0]    cmd_wdata_i,
  input  logic [TAG_W-1:0]     cmd_tag_i,
  output logic                 mem_ena_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_wena_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  input  logic [DATA_W-1:0]    mem_rdata_i,
  input  logic                 mem_err_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATA_W-1:0]    rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 rsp_wena_o,
  output logic [TAG_W-1:0]     rsp_tag_o,
  output logic                 busy_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  if (DATA_W != RSP_DATA_W || TAG_W != RSP_TAG_W || RSP_DEPTH < 2) begin : g_param_chk
    $error("regf_mem_master: widths must match rsp_entry_t and RSP_DEPTH must be >= 2");
  end

  localparam int CW = $clog2(RSP_DEPTH+1);
  localparam int IW = CW + 1;

  logic                 clr;
  logic                 fire;
  logic                 push;
  logic                 pend;
  logic                 pend_wena;
  logic [TAG_W-1:0]     pend_tag;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [CW-1:0]        occ;
  logic [IW-1:0]        inflight;
  logic                 fifo_full;
  logic                 fifo_empty;
  rsp_entry_t           push_entry;
  rsp_entry_t           head;

  assign clr = main_rst_i || soft_rst_i;

  // Credit: a pop in this cycle frees its slot only from the next cycle on.
  assign inflight    = IW'(occ) + IW'(pend);
  assign cmd_ready_o = !clr && !fifo_full && (inflight < IW'(RSP_DEPTH));
  assign fire        = cmd_valid_i && cmd_ready_o;

  assign mem_ena_o   = fire;
  assign mem_addr_o  = fire ? cmd_addr_i  : '0;
  assign mem_wena_o  = fire ? cmd_wena_i  : 1'b0;
  assign mem_wdata_o = fire ? cmd_wdata_i : '0;

  // The responder's data belongs to last cycle's access; a flush in this cycle drops it.
  assign push = pend && !clr;

  always_comb begin
    push_entry       = '0;
    push_entry.rdata = pend_wena ? '0 : mem_rdata_i;
    push_entry.err   = mem_err_i;
    push_entry.wena  = pend_wena;
    push_entry.tag   = pend_tag;
  end

  always_ff @(posedge main_clk_i) begin
    if (clr) begin
      pend      <= 1'b0;
      pend_wena <= 1'b0;
      pend_tag  <= '0;
      err_cnt   <= '0;
    end else begin
      pend <= fire;
      if (fire) begin
        pend_wena <= cmd_wena_i;
        pend_tag  <= cmd_tag_i;
      end
      if (push && mem_err_i && (err_cnt != ERR_CNT_MAX)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  regf_mem_master_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     ($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clk       (main_clk_i),
    .flush     (clr),
    .push      (push),
    .push_data (push_entry),
    .pop       (rsp_ready_i),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occ       (occ)
  );

  // Stale storage is masked so every response field reads 0 while nothing is buffered.
  assign rsp_valid_o = !fifo_empty;
  assign rsp_rdata_o = fifo_empty ? '0   : head.rdata;
  assign rsp_err_o   = fifo_empty ? 1'b0 : head.err;
  assign rsp_wena_o  = fifo_empty ? 1'b0 : head.wena;
  assign rsp_tag_o   = fifo_empty ? '0   : head.tag;

  assign busy_o    = pend || !fifo_empty;
  assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_regf_mem_master.sv
// Directed bench: a regf responder model, a scoreboard of expected responses and a monitor on the rsp stream.
module tb_regf_mem_master;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = 4;
  localparam int RSP_DEPTH = 3;

  logic              clk = 1'b0;
  logic              main_rst_i;
  logic              soft_rst_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic              cmd_wena_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic [TAG_W-1:0]  cmd_tag_i;
  logic              mem_ena_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_wena_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_err_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              rsp_wena_o;
  logic [TAG_W-1:0]  rsp_tag_o;
  logic              busy_o;
  logic [7:0]        err_cnt_o;

  always #5 clk = ~clk;

  regf_mem_master #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .TAG_W     (TAG_W),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .main_clk_i  (clk),
    .main_rst_i  (main_rst_i),
    .soft_rst_i  (soft_rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wena_i  (cmd_wena_i),
    .cmd_wdata_i (cmd_wdata_i),
    .cmd_tag_i   (cmd_tag_i),
    .mem_ena_o   (mem_ena_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wena_o  (mem_wena_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_err_i   (mem_err_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_wena_o  (rsp_wena_o),
    .rsp_tag_o   (rsp_tag_o),
    .busy_o      (busy_o),
    .err_cnt_o   (err_cnt_o)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        wena;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_pops = 0;
  logic err_all = 1'b0;

  // Responder: rdata = 0xCAFE0000 + addr/4 one cycle after the strobe; err on 0x1FFC or when err_all.
  // Outside a response cycle it drives junk with err=1 so stray sampling shows up.
  logic              resp_ena_q  = 1'b0;
  logic [ADDR_W-1:0] resp_addr_q = '0;
  always @(posedge clk) begin
    resp_ena_q  <= mem_ena_o;
    resp_addr_q <= mem_addr_o;
  end
  assign mem_rdata_i = resp_ena_q ? (32'hCAFE_0000 + 32'(resp_addr_q >> 2)) : 32'hDEAD_BEEF;
  assign mem_err_i   = resp_ena_q ? (err_all || (resp_addr_q == 13'h1FFC)) : 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted response is compared against the scoreboard head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!main_rst_i && !soft_rst_i && rsp_valid_o && rsp_ready_i) begin
      n_pops++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata_o, e.rdata);
        chk("rsp_err",   32'(rsp_err_o),  32'(e.err));
        chk("rsp_wena",  32'(rsp_wena_o), 32'(e.wena));
        chk("rsp_tag",   32'(rsp_tag_o),  32'(e.tag));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the fire.
  task automatic send(input logic [12:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] t, input logic [31:0] er, input logic ee,
                      output int waits);
    exp_t e;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_wena_i  = w;
    cmd_wdata_i = wd;
    cmd_tag_i   = t;
    waits = 0;
    @(negedge clk);
    while (!cmd_ready_o && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!cmd_ready_o) begin
      chk("cmd_accept_timeout", 32'd0, 32'd1);
    end else begin
      chk("fire_mem_ena",   32'(mem_ena_o),  32'd1);
      chk("fire_mem_addr",  32'(mem_addr_o), 32'(a));
      chk("fire_mem_wena",  32'(mem_wena_o), 32'(w));
      chk("fire_mem_wdata", mem_wdata_o, wd);
      e = {er, ee, w, t};
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = 13'h0ABC;
    cmd_wena_i  = 1'b1;
    cmd_wdata_i = 32'h1234_5678;
    cmd_tag_i   = 4'hF;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   w;
    int   nf;
    int   base;
    exp_t e;

    main_rst_i  = 1'b1;
    soft_rst_i  = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = 13'h0123;
    cmd_wena_i  = 1'b0;
    cmd_wdata_i = 32'h0;
    cmd_tag_i   = 4'h0;
    rsp_ready_i = 1'b1;

    // Reset: no credit and no strobe while reset is high, even with a valid command.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    chk("rst_mem_ena",   32'(mem_ena_o),   32'd0);
    @(posedge clk); #1;
    main_rst_i  = 1'b0;
    cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("post_rst_busy",      32'(busy_o),      32'd0);
    chk("post_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("post_rst_err_cnt",   32'(err_cnt_o),   32'd0);
    chk("post_rst_mem_ena",   32'(mem_ena_o),   32'd0);
    chk("post_rst_rsp_rdata", rsp_rdata_o,      32'd0);
    @(posedge clk); #1;

    // Single read: strobe in cycle 0 only, response in cycle 2.
    send(13'h0004, 1'b0, 32'h0, 4'h3, 32'hCAFE_0001, 1'b0, w);
    @(negedge clk);
    chk("rd_c1_mem_ena",   32'(mem_ena_o),   32'd0);
    chk("rd_c1_mem_addr",  32'(mem_addr_o),  32'd0);
    chk("rd_c1_mem_wena",  32'(mem_wena_o),  32'd0);
    chk("rd_c1_mem_wdata", mem_wdata_o,      32'd0);
    chk("rd_c1_busy",      32'(busy_o),      32'd1);
    chk("rd_c1_rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    chk("rd_c2_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("rd_c2_busy",      32'(busy_o),      32'd1);
    @(negedge clk);
    chk("rd_c3_busy",      32'(busy_o),      32'd0);
    @(posedge clk); #1;

    // Write with error: rdata forced to 0, error counted once.
    send(13'h1FFC, 1'b1, 32'h0000_00A5, 4'h5, 32'h0, 1'b1, w);
    @(negedge clk);
    @(negedge clk);
    chk("wr_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("wr_err_cnt",   32'(err_cnt_o),   32'd1);
    @(posedge clk); #1;

    // Backpressure: exactly RSP_DEPTH fires, then no credit until a pop has completed.
    rsp_ready_i = 1'b0;
    nf          = 0;
    cmd_valid_i = 1'b1;
    cmd_wena_i  = 1'b0;
    cmd_wdata_i = 32'h0;
    cmd_tag_i   = 4'h0;
    cmd_addr_i  = 13'h0010;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        e = {32'hCAFE_0004 + 32'(nf), 1'b0, 1'b0, 4'(nf)};
        sb.push_back(e);
        nf++;
      end else if (c == 7) begin
        chk("bp_stall_mem_ena",  32'(mem_ena_o),  32'd0);
        chk("bp_stall_mem_addr", 32'(mem_addr_o), 32'd0);
      end
      @(posedge clk); #1;
      cmd_tag_i  = 4'(nf);
      cmd_addr_i = 13'h0010 + 13'(nf * 4);
    end
    chk("bp_fire_count", 32'(nf), 32'd3);
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_no_bypass_ready", 32'(cmd_ready_o), 32'd0);
    chk("bp_rsp_valid",       32'(rsp_valid_o), 32'd1);
    @(negedge clk);
    chk("bp_ready_after_pop", 32'(cmd_ready_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("bp_drained_busy", 32'(busy_o), 32'd0);
    chk("bp_sb_empty",     32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Streaming: 16 back-to-back reads, first response in cycle 2, one pop per cycle after.
    base = n_pops;
    for (int i = 0; i < 16; i++) begin
      send(13'h0200 + 13'(i * 4), 1'b0, 32'h0, 4'(i), 32'hCAFE_0080 + 32'(i), 1'b0, w);
      chk("stream_bubble", 32'(w), 32'd0);
      chk("stream_pops", 32'(n_pops - base), (i >= 1) ? 32'(i - 1) : 32'd0);
    end
    repeat (4) @(negedge clk);
    chk("stream_total_pops", 32'(n_pops - base), 32'd16);
    chk("stream_sb_empty",   32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Soft reset with 2 buffered and 1 pending: everything dropped, err_cnt cleared.
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(13'h0100 + 13'(i * 4), 1'b0, 32'h0, 4'(8 + i), 32'hCAFE_0040 + 32'(i), 1'b0, w);
      chk("srst_fill_nowait", 32'(w), 32'd0);
    end
    soft_rst_i  = 1'b1;
    cmd_valid_i = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("srst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    chk("srst_mem_ena",   32'(mem_ena_o),   32'd0);
    @(posedge clk); #1;
    soft_rst_i  = 1'b0;
    cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("srst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("srst_busy",      32'(busy_o),      32'd0);
    chk("srst_err_cnt",   32'(err_cnt_o),   32'd0);
    chk("srst_cmd_ready_after", 32'(cmd_ready_o), 32'd1);
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("srst_no_stale_rsp", 32'(rsp_valid_o), 32'd0);
    end
    @(posedge clk); #1;

    // Error saturation: 300 erroring reads, counter stops at 255.
    err_all = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(13'(i * 4), 1'b0, 32'h0, 4'(i), 32'hCAFE_0000 + 32'(i), 1'b1, w);
      if (i == 9 || i == 254 || i == 299) begin
        chk("sat_err_cnt_progress", 32'(err_cnt_o), (i > 255) ? 32'd255 : 32'(i));
      end
    end
    repeat (4) @(negedge clk);
    chk("sat_err_cnt_hold", 32'(err_cnt_o), 32'd255);
    chk("sat_sb_empty",     32'(sb.size()), 32'd0);
    err_all = 1'b0;
    @(posedge clk); #1;
    main_rst_i = 1'b1;
    @(posedge clk); #1;
    main_rst_i = 1'b0;
    @(negedge clk);
    chk("sat_err_cnt_reset", 32'(err_cnt_o),   32'd0);
    chk("sat_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("sat_rst_busy",      32'(busy_o),      32'd0);

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regf_mem_master.md
Name: regf_mem_master

Overview:
- Bus initiator for the register-file `mem_*` interface: it drives the port that the generated `*_regf` modules implement as responder.
- Accepts access commands on a valid/ready stream and issues each one as a single-cycle `mem` access.
- Captures the read data and error returned one cycle later, and delivers them in order on a buffered valid/ready response stream.
- Sits between a CPU/debug/sequencer front end and one regf instance.

Parameters:
- `ADDR_W`, 13, mem address width.
- `DATA_W`, 32, mem data width.
- `TAG_W`, 4, width of the opaque command tag echoed on the response.
- `RSP_DEPTH`, 3, response FIFO entries; minimum 2; 3 or more gives full throughput.

Ports:
- `main_clk_i`  in  1  clock.
- `main_rst_i`  in  1  reset, synchronous, active-high.
- `soft_rst_i`  in  1  synchronous flush, same effect as reset.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command accepted when `cmd_valid_i` and `cmd_ready_o` are both high.
- `cmd_addr_i`  in  `ADDR_W`  target address.
- `cmd_wena_i`  in  1  1 = write, 0 = read.
- `cmd_wdata_i`  in  `DATA_W`  write data.
- `cmd_tag_i`  in  `TAG_W`  tag.
- `mem_ena_o`  out  1  access strobe.
- `mem_addr_o`  out  `ADDR_W`  access address.
- `mem_wena_o`  out  1  write enable.
- `mem_wdata_o`  out  `DATA_W`  write data.
- `mem_rdata_i`  in  `DATA_W`  read data, valid the cycle after `mem_ena_o`.
- `mem_err_i`  in  1  access error, valid the cycle after `mem_ena_o`.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed when `rsp_valid_o` and `rsp_ready_i` are both high.
- `rsp_rdata_o`  out  `DATA_W`  read data; 0 for writes.
- `rsp_err_o`  out  1  error flag.
- `rsp_wena_o`  out  1  echo of `cmd_wena_i`.
- `rsp_tag_o`  out  `TAG_W`  echo of `cmd_tag_i`.
- `busy_o`  out  1  an access is in flight or a response is buffered.
- `err_cnt_o`  out  8  saturating count of erroring accesses.

Behaviour:
- Reset and flush: `main_rst_i` or `soft_rst_i` high at a clock edge gives:
  - pending flag = 0, FIFO empty, `err_cnt_o` = 0;
  - all outputs 0 afterwards, except `cmd_ready_o`, which is 1 in the cycle after reset deasserts.
  - `soft_rst_i` has the same effect, and also discards an in-flight response whose `mem_rdata_i` arrives in the flush cycle.
  - While either reset is high: `cmd_ready_o` = 0 and `mem_ena_o` = 0.
- Credit rule:
  - `inflight` = FIFO occupancy + pending flag.
  - `cmd_ready_o` = (`inflight` < `RSP_DEPTH`) and not in reset.
  - A pop in the same cycle does not add credit (no bypass).
- Issue stage (combinational from `cmd_*`, no register):
  - `mem_ena_o` = fire (`cmd_valid_i` and `cmd_ready_o`).
  - `mem_addr_o`, `mem_wena_o`, `mem_wdata_o` equal the `cmd_*` fields when fire, else 0.
  - Write data is driven even for reads when fire.
- Pending stage, for an access fired in cycle T:
  - pending flag is set for T+1, and `cmd_tag_i`/`cmd_wena_i` are registered alongside it.
  - In T+1 the module samples `mem_rdata_i` and `mem_err_i` and pushes {rdata, err, wena, tag} into the FIFO at the end of T+1.
  - Rdata is forced to 0 when wena = 1.
  - Back-to-back fires keep the pending flag high every cycle.
- Response:
  - `rsp_valid_o` is high from T+2 while the FIFO is non-empty; the `rsp_*` fields show the head entry.
  - Pop on `rsp_valid_o` and `rsp_ready_i` both high.
  - Minimum latency from command fire to `rsp_valid_o` is 2 cycles.
  - Responses are strictly in command order.
- FIFO:
  - Circular buffer of `RSP_DEPTH` entries, with pointer wrap at `RSP_DEPTH`-1 and an occupancy counter.
  - A push is never refused, because credit guarantees space.
  - Simultaneous push and pop leaves occupancy unchanged.
- Throughput: with `RSP_DEPTH` ≥ 3 and `rsp_ready_i` held at 1, one command is accepted per cycle indefinitely. With `RSP_DEPTH` = 2, at most 2 commands are accepted in any 3 consecutive cycles.
- `err_cnt_o`: increments by 1 on each FIFO push whose err = 1, saturating at 255.
- `busy_o` = pending flag OR FIFO non-empty (registered state only).
- `rsp_ready_i` high with the FIFO empty has no effect.

Decomposition:
- Package `regf_mem_master_pkg` holds:
  - `rsp_entry_t` (packed struct {rdata, err, wena, tag}), parameterised via the module's widths;
  - `ERR_CNT_W` = 8;
  - `ERR_CNT_MAX` = 8'hFF.
- One sub-module, `regf_mem_master_fifo`: synchronous FIFO with parameters depth and entry width; ports push/pop/flush; outputs full/empty/occupancy.

Test Plan:
- Single read:
  - Stimulus: cmd addr 13'h0004, wena 0, tag 4'h3 in cycle 0; regf returns rdata 32'hCAFE_0001, err 0 in cycle 1.
  - Expected: `mem_ena_o` = 1 in cycle 0 only; `rsp_valid_o` = 1 in cycle 2 with rdata 32'hCAFE_0001, err 0, tag 3; `busy_o` = 1 in cycles 1–2.
- Write with error:
  - Stimulus: cmd addr 13'h1FFC, wena 1, wdata 32'h0000_00A5; `mem_err_i` = 1 in the response cycle.
  - Expected: `mem_wdata_o` = 32'h0000_00A5 in the fire cycle; rsp err 1, rdata 0, wena 1; `err_cnt_o` = 1.
- Backpressure:
  - Stimulus: `rsp_ready_i` = 0 with `cmd_valid_i` held at 1, `RSP_DEPTH` = 3.
  - Expected: exactly 3 fires, then `cmd_ready_o` = 0.
  - Then: raising `rsp_ready_i` delivers tags 0, 1, 2 in order, and `cmd_ready_o` returns to 1 the cycle after the first pop.
- Streaming:
  - Stimulus: 16 back-to-back reads with `rsp_ready_i` = 1 and `RSP_DEPTH` = 3.
  - Expected: 16 consecutive fire cycles with no bubble; 16 responses in order; first response at cycle 2.
- Soft reset mid-operation:
  - Stimulus: 2 responses buffered and 1 pending, then `soft_rst_i` pulsed for 1 cycle.
  - Expected: the next cycle has `rsp_valid_o` = 0, `busy_o` = 0, `err_cnt_o` = 0, `cmd_ready_o` = 1; the pending response is not delivered.
- Error saturation:
  - Stimulus: 300 accesses with `mem_err_i` = 1.
  - Expected: `err_cnt_o` stops at 255 and holds until reset.
